// File: rtl/boot_sequencer.sv
// boot_sequencer: streams a program ROM into the pipeline load port, releases
// the pipeline, polls the data-memory completion flag, reads back the result
// word and reports done or timeout.
module boot_sequencer #(
    parameter int unsigned PROG_WORDS  = 100,
    parameter int unsigned RUN_TIMEOUT = 4096,
    parameter int unsigned DONE_ADDR   = 0,
    parameter int unsigned RESULT_ADDR = 1,
    parameter int unsigned SETTLE      = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    output logic [9:0]  rom_addr,
    input  logic [31:0] rom_data,
    output logic        pl_start,
    output logic [31:0] pl_address,
    output logic [31:0] pl_instruction,
    output logic        pl_data_or_reg,
    output logic [31:0] pl_check_address,
    input  logic [31:0] pl_value,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [31:0] result,
    output logic [31:0] run_cycles
);

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;

    localparam logic [AW-1:0] LAST_WORD   = AW'(PROG_WORDS - 1);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE);
    localparam logic [DW-1:0] DONE_A      = DW'(DONE_ADDR);
    localparam logic [DW-1:0] RESULT_A    = DW'(RESULT_ADDR);
    localparam logic [DW-1:0] TIMEOUT_LIM = DW'(RUN_TIMEOUT);
    localparam logic [DW-1:0] CYCLES_MAX  = '1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PRIME   = 3'd1;
    localparam logic [2:0] S_LOAD    = 3'd2;
    localparam logic [2:0] S_RUN     = 3'd3;
    localparam logic [2:0] S_POLL    = 3'd4;
    localparam logic [2:0] S_READ    = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;
    localparam logic [2:0] S_TIMEOUT = 3'd7;

    logic [2:0]    state, state_d;
    logic [AW-1:0] word_idx, word_idx_d;
    logic [SW-1:0] settle_cnt, settle_cnt_d;
    logic [AW-1:0] rom_addr_d;
    logic          pl_start_d;
    logic [DW-1:0] pl_address_d;
    logic [DW-1:0] pl_instruction_d;
    logic          pl_data_or_reg_d;
    logic [DW-1:0] pl_check_address_d;
    logic          busy_d;
    logic          done_d;
    logic          timeout_d;
    logic [DW-1:0] result_d;
    logic [DW-1:0] run_cycles_d;
    logic          in_run;

    // ROM prefetch address, clamped to the last program word
    function automatic logic [AW-1:0] clamp_addr(input logic [AW:0] a);
        if (a > {1'b0, LAST_WORD}) begin
            return LAST_WORD;
        end
        return a[AW-1:0];
    endfunction

    assign in_run = (state == S_RUN) || (state == S_POLL) || (state == S_READ);

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            word_idx         <= '0;
            settle_cnt       <= '0;
            rom_addr         <= '0;
            pl_start         <= 1'b1;
            pl_address       <= '0;
            pl_instruction   <= '0;
            pl_data_or_reg   <= 1'b1;
            pl_check_address <= DONE_A;
            busy             <= 1'b0;
            done             <= 1'b0;
            timeout          <= 1'b0;
            result           <= '0;
            run_cycles       <= '0;
        end else begin
            state            <= state_d;
            word_idx         <= word_idx_d;
            settle_cnt       <= settle_cnt_d;
            rom_addr         <= rom_addr_d;
            pl_start         <= pl_start_d;
            pl_address       <= pl_address_d;
            pl_instruction   <= pl_instruction_d;
            pl_data_or_reg   <= pl_data_or_reg_d;
            pl_check_address <= pl_check_address_d;
            busy             <= busy_d;
            done             <= done_d;
            timeout          <= timeout_d;
            result           <= result_d;
            run_cycles       <= run_cycles_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d            = state;
        word_idx_d         = word_idx;
        settle_cnt_d       = settle_cnt;
        rom_addr_d         = rom_addr;
        pl_start_d         = pl_start;
        pl_address_d       = pl_address;
        pl_instruction_d   = pl_instruction;
        pl_data_or_reg_d   = pl_data_or_reg;
        pl_check_address_d = pl_check_address;
        busy_d             = busy;
        done_d             = done;
        timeout_d          = timeout;
        result_d           = result;
        run_cycles_d       = run_cycles;

        case (state)
            S_IDLE, S_DONE, S_TIMEOUT: begin
                // Launch (or relaunch) from a clean, pipeline-held state
                if (go) begin
                    state_d            = S_PRIME;
                    word_idx_d         = '0;
                    rom_addr_d         = '0;
                    pl_start_d         = 1'b1;
                    pl_address_d       = '0;
                    pl_instruction_d   = '0;
                    pl_data_or_reg_d   = 1'b1;
                    pl_check_address_d = DONE_A;
                    busy_d             = 1'b1;
                    done_d             = 1'b0;
                    timeout_d          = 1'b0;
                    result_d           = '0;
                    run_cycles_d       = '0;
                end
            end

            S_PRIME: begin
                // Word 0 is being read; start fetching word 1
                rom_addr_d = clamp_addr((AW + 1)'(1));
                word_idx_d = '0;
                state_d    = S_LOAD;
            end

            S_LOAD: begin
                // Present word k for one cycle while the ROM fetches k+2
                pl_address_d     = DW'(word_idx);
                pl_instruction_d = rom_data;
                rom_addr_d       = clamp_addr((AW + 1)'(word_idx) + (AW + 1)'(2));
                word_idx_d       = word_idx + AW'(1);
                if (word_idx == LAST_WORD) begin
                    state_d      = S_RUN;
                    settle_cnt_d = SETTLE_LOAD;
                end
            end

            S_RUN: begin
                // Release the pipeline and let the check port settle on the flag word
                pl_start_d         = 1'b0;
                pl_data_or_reg_d   = 1'b1;
                pl_check_address_d = DONE_A;
                if (settle_cnt <= SW'(1)) begin
                    state_d = S_POLL;
                end else begin
                    settle_cnt_d = settle_cnt - SW'(1);
                end
            end

            S_POLL: begin
                if (pl_value == DW'(1)) begin
                    state_d            = S_READ;
                    pl_check_address_d = RESULT_A;
                    settle_cnt_d       = SETTLE_LOAD;
                end
            end

            S_READ: begin
                if (settle_cnt <= SW'(1)) begin
                    result_d = pl_value;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = S_DONE;
                end else begin
                    settle_cnt_d = settle_cnt - SW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Run-time accounting; completion in the same cycle beats the timeout
        if (in_run) begin
            if (run_cycles != CYCLES_MAX) begin
                run_cycles_d = run_cycles + DW'(1);
            end
            if ((state_d != S_DONE) && (run_cycles_d >= TIMEOUT_LIM)) begin
                state_d    = S_TIMEOUT;
                timeout_d  = 1'b1;
                busy_d     = 1'b0;
                pl_start_d = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_boot_sequencer.sv
// Directed bench for boot_sequencer with a ROM model and a minimal pipeline
// check-port model whose completion flag rises a set number of cycles after release.
module tb_boot_sequencer;

    localparam int unsigned PW  = 4;
    localparam int unsigned TMO = 64;
    localparam int unsigned DA  = 0;
    localparam int unsigned RA  = 1;
    localparam int unsigned ST  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        go;
    logic [9:0]  rom_addr;
    logic [31:0] rom_data;
    logic        pl_start;
    logic [31:0] pl_address;
    logic [31:0] pl_instruction;
    logic        pl_data_or_reg;
    logic [31:0] pl_check_address;
    logic [31:0] pl_value;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [31:0] result;
    logic [31:0] run_cycles;

    logic [31:0] rom [0:3];
    int          flag_at;
    int          rel_cnt;
    logic        dflag;
    logic [31:0] res_val;

    int n_checks = 0;
    int n_pass   = 0;

    boot_sequencer #(
        .PROG_WORDS (PW),
        .RUN_TIMEOUT(TMO),
        .DONE_ADDR  (DA),
        .RESULT_ADDR(RA),
        .SETTLE     (ST)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .go              (go),
        .rom_addr        (rom_addr),
        .rom_data        (rom_data),
        .pl_start        (pl_start),
        .pl_address      (pl_address),
        .pl_instruction  (pl_instruction),
        .pl_data_or_reg  (pl_data_or_reg),
        .pl_check_address(pl_check_address),
        .pl_value        (pl_value),
        .busy            (busy),
        .done            (done),
        .timeout         (timeout),
        .result          (result),
        .run_cycles      (run_cycles)
    );

    always #5 clk = ~clk;

    // Synchronous program ROM, one-cycle read latency
    always @(posedge clk) begin
        rom_data <= (rom_addr < 10'(PW)) ? rom[rom_addr[1:0]] : 32'h0;
    end

    // Pipeline model: flag word goes to 1 flag_at cycles after release
    always @(posedge clk) begin
        if (pl_start) begin
            rel_cnt <= 0;
            dflag   <= 1'b0;
        end else begin
            rel_cnt <= rel_cnt + 1;
            if (rel_cnt + 1 == flag_at) dflag <= 1'b1;
        end
    end

    assign pl_value = (pl_check_address == 32'(DA)) ? {31'b0, dflag} :
                      (pl_check_address == 32'(RA)) ? res_val : 32'hdead_beef;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Launch, then follow the load word by word; optionally poke go or reset mid-load
    task automatic start_and_load(input bit poke, input int abort_at);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        check("prime_busy",    32'(busy), 1);
        check("prime_done",    32'(done), 0);
        check("prime_timeout", 32'(timeout), 0);
        check("prime_result",  result, 0);
        check("prime_cycles",  run_cycles, 0);
        check("prime_rom_addr", 32'(rom_addr), 0);
        check("prime_start",   32'(pl_start), 1);
        @(negedge clk);
        check("load_rom_addr1", 32'(rom_addr), 1);
        for (int k = 0; k < int'(PW); k++) begin
            @(negedge clk);
            check("load_addr",  pl_address, 32'(k));
            check("load_instr", pl_instruction, rom[k]);
            check("load_start", 32'(pl_start), 1);
            if (poke) go = (k == 1);
            if (k == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("rst_start", 32'(pl_start), 1);
                check("rst_busy",  32'(busy), 0);
                check("rst_addr",  pl_address, 0);
                return;
            end
        end
        go = 1'b0;
        @(negedge clk);
        check("release_start", 32'(pl_start), 0);
    endtask

    task automatic wait_end();
        for (int i = 0; i < 300 && busy; i++) @(negedge clk);
        check("end_reached", 32'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rom[0] = 32'h0050_0093;
        rom[1] = 32'h0010_0113;
        rom[2] = 32'h0020_81B3;
        rom[3] = 32'h0030_2023;
        rst = 1'b1; go = 1'b0; flag_at = -1; res_val = '0;
        repeat (3) @(negedge clk);

        check("rst_pl_start",  32'(pl_start), 1);
        check("rst_busy0",     32'(busy), 0);
        check("rst_done",      32'(done), 0);
        check("rst_timeout",   32'(timeout), 0);
        check("rst_result",    result, 0);
        check("rst_cycles",    run_cycles, 0);
        check("rst_instr",     pl_instruction, 0);
        check("rst_dor",       32'(pl_data_or_reg), 1);
        check("rst_chk_addr",  pl_check_address, 32'(DA));
        check("rst_rom_addr",  32'(rom_addr), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 0);

        // Normal completion: flag 50 cycles after release, result 42
        flag_at = 50; res_val = 32'd42;
        start_and_load(1'b0, -1);
        wait_end();
        check("a_done",     32'(done), 1);
        check("a_result",   result, 42);
        check("a_timeout",  32'(timeout), 0);
        check("a_cycles_window", 32'(run_cycles >= 53 && run_cycles <= 55), 1);
        check("a_chk_addr", pl_check_address, 32'(RA));
        check("a_start",    32'(pl_start), 0);
        repeat (5) @(negedge clk);
        check("a_done_sticky",   32'(done), 1);
        check("a_result_stable", result, 42);

        // Restart from DONE; flag never set, so time out
        flag_at = -1; res_val = 32'd99;
        start_and_load(1'b0, -1);
        wait_end();
        check("b_timeout", 32'(timeout), 1);
        check("b_done",    32'(done), 0);
        check("b_start",   32'(pl_start), 1);
        check("b_cycles",  run_cycles, 32'(TMO));
        check("b_result",  result, 0);

        // Flag and timeout land together: done wins
        flag_at = 60; res_val = 32'h1234_5678;
        start_and_load(1'b0, -1);
        wait_end();
        check("c_done",    32'(done), 1);
        check("c_timeout", 32'(timeout), 0);
        check("c_result",  result, 32'h1234_5678);
        check("c_cycles",  run_cycles, 32'(TMO));

        // Flag one cycle later: timeout wins
        flag_at = 61; res_val = 32'd5;
        start_and_load(1'b0, -1);
        wait_end();
        check("d_timeout", 32'(timeout), 1);
        check("d_done",    32'(done), 0);
        check("d_result",  result, 0);

        // go during LOAD and POLL is ignored
        flag_at = 20; res_val = 32'd7;
        start_and_load(1'b1, -1);
        repeat (5) @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        check("e_poll_start",  32'(pl_start), 0);
        check("e_poll_busy",   32'(busy), 1);
        check("e_poll_cycles", 32'(run_cycles != 0), 1);
        wait_end();
        check("e_done",   32'(done), 1);
        check("e_result", result, 7);

        // Reset after word 2, then a full reload
        flag_at = 5; res_val = 32'd9;
        start_and_load(1'b0, 2);
        start_and_load(1'b0, -1);
        wait_end();
        check("f_done",   32'(done), 1);
        check("f_result", result, 9);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/boot_sequencer.md
Name: boot_sequencer

Overview:
- Controller that sequences the RISC-V pipeline's program-load / run / result-readback flow. It replaces the hand-written stimulus loop in simulation and on-board.
- Streams PROG_WORDS instruction words from a synchronous program ROM into the pipeline's load port while holding start high, then releases start.
- Polls the pipeline's check port for the completion flag, reads back the result word, and reports done or timeout.

Parameters:
- PROG_WORDS, 100, number of instruction words loaded (1..1024)
- RUN_TIMEOUT, 4096, max RUN/POLL cycles before timeout
- DONE_ADDR, 0, data-memory word polled for completion flag (==1)
- RESULT_ADDR, 1, data-memory word read back as result
- SETTLE, 1, cycles waited after changing check_address before sampling value (1..15)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- go  in  1  single-cycle launch request
- rom_addr  out  10  program ROM word address
- rom_data  in  32  ROM read data, valid 1 cycle after rom_addr
- pl_start  out  1  pipeline start (1 = load/hold, 0 = run)
- pl_address  out  32  pipeline load word address
- pl_instruction  out  32  pipeline load word
- pl_data_or_reg  out  1  pipeline check-port select (1 = data memory)
- pl_check_address  out  32  pipeline check-port address
- pl_value  in  32  pipeline check-port read value
- busy  out  1  sequence in progress
- done  out  1  sticky, completion flag seen and result captured
- timeout  out  1  sticky, RUN_TIMEOUT exceeded
- result  out  32  captured RESULT_ADDR word
- run_cycles  out  32  cycles spent in RUN/POLL

Behaviour:
- All outputs registered. Synchronous reset, any cycle including mid-sequence, gives:
  - state IDLE
  - pl_start=1, so the pipeline never runs stale code
  - pl_address=0, pl_instruction=0, pl_data_or_reg=1, pl_check_address=DONE_ADDR
  - rom_addr=0, busy=0, done=0, timeout=0, result=0, run_cycles=0
- IDLE:
  - go=1 → PRIME: rom_addr=0, busy=1, clear done/timeout/result/run_cycles.
  - go is ignored while busy.
  - go in DONE/TIMEOUT restarts the sequence identically.
- PRIME (1 cycle):
  - rom_addr←1 → LOAD.
- LOAD:
  - Each cycle, pl_address←k and pl_instruction←rom_data (word k); rom_addr←k+2 (saturating at PROG_WORDS-1); k increments.
  - Word k is presented for exactly one cycle; pl_address is consecutive 0..PROG_WORDS-1 with no gaps.
  - pl_start=1 throughout.
  - After word PROG_WORDS-1 is driven → RUN.
- RUN:
  - Entry cycle: pl_start←0, pl_data_or_reg←1, pl_check_address←DONE_ADDR.
  - A SETTLE counter is loaded; when it expires → POLL.
- POLL:
  - Sample pl_value every cycle.
  - pl_value==32'd1 → READ: pl_check_address←RESULT_ADDR, SETTLE counter reloaded.
- READ:
  - On settle expiry: result←pl_value, done←1, busy←0 → DONE.
  - pl_start stays 0.
- Timeout:
  - run_cycles increments every cycle in RUN/POLL/READ, saturating at 2^32-1.
  - If run_cycles reaches RUN_TIMEOUT before done: timeout←1, busy←0, pl_start←1 (halt pipeline) → TIMEOUT.
  - If the completion flag and the timeout occur in the same cycle, done wins.
- DONE and TIMEOUT:
  - Hold all outputs stable until go or rst.
  - done and timeout are never both 1.
- PROG_WORDS=1 boundary: LOAD lasts exactly 1 cycle.
- Values of pl_value outside POLL/READ sample points are ignored.

Test Plan:
- Reset then go, PROG_WORDS=4, ROM={0x00500093,0x00100113,0x002081B3,0x00302023} → pl_address 0,1,2,3 on consecutive cycles with matching pl_instruction; pl_start=1 through the last word, 0 on the next cycle.
- Pipeline model writes 1 to DONE_ADDR 50 cycles after release and 42 to RESULT_ADDR → done=1, result=42, timeout=0, run_cycles≈50+2·SETTLE (±1).
- Model never sets the flag, RUN_TIMEOUT=64 → timeout=1 after 64 run cycles, pl_start=1, done=0, busy=0.
- rst asserted mid-LOAD (after word 2) → next cycle IDLE, pl_start=1, busy=0. Subsequent go reloads from word 0.
- go pulsed during LOAD and POLL → ignored, load sequence uninterrupted. go in DONE → full restart, done/result cleared on the PRIME cycle.
- Flag and timeout coincide (flag at run cycle RUN_TIMEOUT-SETTLE-1 with result read landing at timeout) → done=1, timeout=0.
